wb_io_byte_port: RTL and testbench

//  Wishbone B3 classic responder for the CPU's I/O space: a byte-wide data port

---
 rtl/wb_io_byte_port_pkg.sv | 30 +++
 rtl/wb_io_byte_port_if.sv | 26 ++
 rtl/wb_io_byte_port_fifo.sv | 47 ++++
 rtl/wb_io_byte_port.sv | 107 ++++++++++
 tb/tb_wb_io_byte_port.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_io_byte_port_pkg.sv
// Shared definitions for the Wishbone I/O byte port: status bit positions,
// byte-lane indices, default port address and the status byte builder.
package wb_io_byte_port_pkg;

    localparam logic [14:0] IO_WADR_DEF = 15'h05b;

    localparam int LANE_DATA = 0;
    localparam int LANE_STAT = 1;

    localparam int ST_RXNE   = 0;
    localparam int ST_TXF    = 1;
    localparam int ST_TXDROP = 2;
    localparam int ST_TXE    = 3;

    function automatic logic [7:0] status_byte(
        input logic txe,
        input logic drop,
        input logic txf,
        input logic rxne
    );
        logic [7:0] s;
        s            = '0;
        s[ST_TXE]    = txe;
        s[ST_TXDROP] = drop;
        s[ST_TXF]    = txf;
        s[ST_RXNE]   = rxne;
        return s;
    endfunction

endpackage

// File: rtl/wb_io_byte_port_if.sv
// Wishbone B3 classic bus bundle for the I/O byte port.
// master drives adr/dat_i/sel/we/stb/cyc; slave returns dat_o/ack.
interface wb_io_byte_port_if;

    logic [15:1] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/wb_io_byte_port_fifo.sv
// io_byte_fifo: byte FIFO with AW+1 bit pointers (wrap mod 2*DEPTH).
// Ports: clk, rst, push, pop, din, dout (head, combinational), full, empty.
module io_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        push_ok;
    logic        pop_ok;

    // Full when the wrap bits differ but the index bits match.
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);

    // A push on full is refused even when a pop lands on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign dout = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + (AW+1)'(1);
            if (pop_ok)  rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_io_byte_port.sv
// Wishbone I/O responder: byte DATA port (TX/RX FIFOs) plus STATUS byte.
// Ports: wb_clk_i, wb_rst_i, wb (slave bus), tx_* stream out, rx_* stream in.
module wb_io_byte_port
    import wb_io_byte_port_pkg::*;
#(
    parameter logic [14:0] IO_WADR = IO_WADR_DEF,
    parameter int          DEPTH   = 16,
    parameter int          AW      = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wb_io_byte_port_if.slave         wb,
    output logic                     tx_valid_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_ready_i,
    input  logic                     rx_valid_i,
    input  logic [7:0]               rx_data_i,
    output logic                     rx_ready_o
);

    logic        ack_q;
    logic [15:0] dat_q;
    logic        tx_drop;
    logic        req;
    logic        acc;
    logic        tx_push;
    logic        tx_pop;
    logic        rx_push;
    logic        rx_pop;
    logic        drop_clr;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic [7:0]  st;
    logic [15:0] rd_data;
    logic        unused_dat;

    assign unused_dat = ^{wb.wb_dat_i[15:11], wb.wb_dat_i[9:8]};

    // ack gates req so a held strobe is acked every other cycle.
    assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign acc = req & (wb.wb_adr_i == IO_WADR);

    assign tx_push  = acc & wb.wb_we_i & wb.wb_sel_i[LANE_DATA];
    assign rx_pop   = acc & ~wb.wb_we_i & wb.wb_sel_i[LANE_DATA];
    assign drop_clr = acc & wb.wb_we_i & wb.wb_sel_i[LANE_STAT]
                    & wb.wb_dat_i[8 + ST_TXDROP];
    assign tx_pop   = tx_ready_i & ~tx_empty;
    assign rx_push  = rx_valid_i & ~rx_full;

    // Status reflects state before this edge's push/pop.
    assign st = status_byte(tx_empty, tx_drop, tx_full, ~rx_empty);

    always_comb begin
        rd_data = '0;
        if (acc && !wb.wb_we_i) begin
            if (wb.wb_sel_i[LANE_DATA] && !rx_empty)
                rd_data[7:0] = rx_head;
            if (wb.wb_sel_i[LANE_STAT])
                rd_data[15:8] = st;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            tx_drop <= 1'b0;
        end else begin
            ack_q <= req;
            if (req) dat_q <= rd_data;
            // A fresh drop outranks a clear on the same edge.
            if (tx_push && tx_full) tx_drop <= 1'b1;
            else if (drop_clr)      tx_drop <= 1'b0;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign tx_valid_o  = ~tx_empty;
    assign rx_ready_o  = ~rx_full;

    io_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wb.wb_dat_i[7:0]),
        .dout  (tx_data_o),
        .full  (tx_full),
        .empty (tx_empty)
    );

    io_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data_i),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

endmodule

// File: tb/tb_wb_io_byte_port.sv
// Bench for wb_io_byte_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_io_byte_port;

    localparam logic [14:0] WADR  = 15'h05b;
    localparam logic [14:0] OTHER = 15'h05c;
    localparam int          DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;

    always #5 clk = ~clk;

    wb_io_byte_port_if bus();

    wb_io_byte_port dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb         (bus),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: queues for the FIFOs, a drop flag, expected bus reply.
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_ack;
    bit          m_drop;
    logic [15:0] m_dat;
    bit          m_req;
    bit          m_acc;
    int          m_nt;
    int          m_nr;
    logic [15:0] m_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_ack  = 0;
            m_drop = 0;
            m_dat  = '0;
        end else begin
            m_req = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
            m_acc = m_req && (bus.wb_adr_i == WADR);
            m_nt  = txq.size();
            m_nr  = rxq.size();
            m_rd  = '0;
            if (m_acc && !bus.wb_we_i) begin
                if (bus.wb_sel_i[0] && m_nr > 0) m_rd[7:0] = rxq[0];
                if (bus.wb_sel_i[1])
                    m_rd[15:8] = {4'b0, m_nt == 0, m_drop,
                                  m_nt == DEPTH, m_nr > 0};
            end
            if (m_req) m_dat = m_rd;
            m_ack = m_req;
            if (tx_ready && m_nt > 0) void'(txq.pop_front());
            if (m_acc && bus.wb_we_i && bus.wb_sel_i[1] && bus.wb_dat_i[10])
                m_drop = 0;
            if (m_acc && bus.wb_we_i && bus.wb_sel_i[0]) begin
                if (m_nt == DEPTH) m_drop = 1;
                else txq.push_back(bus.wb_dat_i[7:0]);
            end
            if (m_acc && !bus.wb_we_i && bus.wb_sel_i[0] && m_nr > 0)
                void'(rxq.pop_front());
            if (rx_valid && m_nr < DEPTH) rxq.push_back(rx_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack", 16'(bus.wb_ack_o), 16'(m_ack));
            if (m_ack) chk("dat_o", bus.wb_dat_o, m_dat);
            chk("tx_valid", 16'(tx_valid), 16'(txq.size() > 0));
            if (txq.size() > 0) chk("tx_data", 16'(tx_data), 16'(txq[0]));
            chk("rx_ready", 16'(rx_ready), 16'(rxq.size() < DEPTH));
        end
    end

    task automatic bus_cyc(input logic we, input logic [14:0] adr,
                           input logic [1:0] sel, input logic [15:0] d,
                           output logic [15:0] q);
        int n;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wb_ack_o && n < 8);
        chk("ack_latency", 16'(n), 16'd1);
        q = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [15:0] q;
    logic [7:0]  got[3];
    int          acks;
    int          b2b;
    bit          prev;

    initial begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;

        // Reset values
        #23;
        chk("rst_ack", 16'(bus.wb_ack_o), 16'd0);
        chk("rst_dat", bus.wb_dat_o, 16'h0000);
        chk("rst_txv", 16'(tx_valid), 16'd0);
        chk("rst_rxr", 16'(rx_ready), 16'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single TX write
        bus_cyc(1'b1, WADR, 2'b01, 16'h00A5, q);
        chk("tx_valid_a5", 16'(tx_valid), 16'd1);
        chk("tx_data_a5", 16'(tx_data), 16'h00A5);

        // RX bytes read with both lanes
        rx_send(8'h11);
        rx_send(8'h22);
        bus_cyc(1'b0, WADR, 2'b11, 16'h0000, q);
        chk("rd11_a", q, 16'h0111);
        bus_cyc(1'b0, WADR, 2'b11, 16'h0000, q);
        chk("rd11_b", q, 16'h0122);
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        bus_cyc(1'b0, WADR, 2'b11, 16'h0000, q);
        chk("rd11_c", q, 16'h0800);

        // Fill TX, overflow, drop flag set/clear
        for (int i = 0; i < DEPTH; i++)
            bus_cyc(1'b1, WADR, 2'b01, 16'(8'h40 + i), q);
        bus_cyc(1'b1, WADR, 2'b01, 16'h003C, q);
        chk("tx_head_full", 16'(tx_data), 16'h0040);
        bus_cyc(1'b0, WADR, 2'b10, 16'h0000, q);
        chk("st_drop", q, 16'h0600);
        bus_cyc(1'b1, WADR, 2'b10, 16'h0400, q);
        bus_cyc(1'b0, WADR, 2'b10, 16'h0000, q);
        chk("st_clr", q, 16'h0200);
        bus_cyc(1'b1, WADR, 2'b11, 16'h0477, q);
        bus_cyc(1'b0, WADR, 2'b10, 16'h0000, q);
        chk("st_drop_wins", q, 16'h0600);
        @(negedge clk);
        tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        tx_ready = 1'b0;
        chk("tx_drained", 16'(tx_valid), 16'd0);

        // Held strobe on DATA read
        for (int i = 0; i < 4; i++) rx_send(8'(8'h61 + i));
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = WADR;
        bus.wb_sel_i = 2'b01;
        acks = 0;
        b2b  = 0;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o) begin
                if (acks < 3) got[acks] = bus.wb_dat_o[7:0];
                acks++;
                if (prev) b2b++;
            end
            prev = bus.wb_ack_o;
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        chk("hold_acks", 16'(acks), 16'd3);
        chk("hold_b2b", 16'(b2b), 16'd0);
        chk("hold_d0", 16'(got[0]), 16'h0061);
        chk("hold_d1", 16'(got[1]), 16'h0062);
        chk("hold_d2", 16'(got[2]), 16'h0063);
        bus_cyc(1'b0, WADR, 2'b01, 16'h0000, q);
        chk("hold_left", q, 16'h0064);

        // Foreign address
        bus_cyc(1'b1, OTHER, 2'b11, 16'hFFFF, q);
        bus_cyc(1'b0, OTHER, 2'b11, 16'h0000, q);
        chk("other_rd", q, 16'h0000);

        // Reset in the middle of an acked cycle
        bus_cyc(1'b1, WADR, 2'b01, 16'h0077, q);
        rx_send(8'h5A);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_sel_i = 2'b01;
        @(posedge clk);
        #2;
        chk("pre_rst_ack", 16'(bus.wb_ack_o), 16'd1);
        chk("pre_rst_dat", bus.wb_dat_o, 16'h005A);
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 16'(bus.wb_ack_o), 16'd0);
        chk("mid_rst_dat", bus.wb_dat_o, 16'h0000);
        chk("mid_rst_txv", 16'(tx_valid), 16'd0);
        chk("mid_rst_rxr", 16'(rx_ready), 16'd1);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.wb_cyc_i = ($urandom_range(0, 3) != 0);
            bus.wb_stb_i = bus.wb_cyc_i && ($urandom_range(0, 2) != 0);
            bus.wb_we_i  = $urandom_range(0, 1) == 1;
            bus.wb_sel_i = 2'($urandom_range(0, 3));
            bus.wb_adr_i = ($urandom_range(0, 7) == 0) ? OTHER : WADR;
            bus.wb_dat_i = 16'($urandom);
            tx_ready     = (i < 1500) ? ($urandom_range(0, 5) == 0)
                                      : ($urandom_range(0, 1) == 1);
            rx_valid     = (i < 1500) ? ($urandom_range(0, 1) == 1)
                                      : ($urandom_range(0, 5) == 0);
            rx_data      = 8'($urandom);
        end
        @(negedge clk);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tx_ready     = 1'b0;
        rx_valid     = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
